// File: rtl/clct_busy_mask_cclut.sv
// Busy-mask feedback for the ccLUT 1-of-32 sorter: each accepted winner
// blanks its key and +/-SPREAD neighbours for busy_hold clocks.
module clct_busy_mask_cclut #(
  parameter int MXKEY   = 32,
  parameter int MXKEYB  = 5,
  parameter int MXPATB  = 7,
  parameter int SPREAD  = 2,
  parameter int MXHOLDB = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               launch,
  input  logic [MXKEYB-1:0]  best_key,
  input  logic [MXPATB-1:0]  best_pat,
  input  logic               best_bsy,
  input  logic [2:0]         hit_thresh,
  input  logic [MXHOLDB-1:0] busy_hold,
  input  logic               flush,
  output logic [MXKEY-1:0]   bsy,
  output logic               bsy_any,
  output logic               accept,
  output logic [15:0]        launch_count
);

  logic [MXHOLDB-1:0] cnt_q [MXKEY];
  logic [MXHOLDB-1:0] cnt_d [MXKEY];
  logic [MXKEY-1:0]   bsy_q, bsy_d;
  logic               any_q;
  logic               acc_q, acc_d;
  logic [15:0]        lcnt_q, lcnt_d;
  logic               key_ok;
  logic               unused_pat;

  assign unused_pat = ^best_pat[MXPATB-4:0];

  assign key_ok = int'(best_key) < MXKEY;

  // Flush suppresses acceptance so the launch counter stays put too.
  assign acc_d = launch & ~best_bsy & ~flush & key_ok
               & (best_pat[MXPATB-1:MXPATB-3] >= hit_thresh)
               & (busy_hold != '0);

  assign lcnt_d = (acc_d && lcnt_q != 16'hFFFF) ? lcnt_q + 16'd1
                                                 : lcnt_q;

  always_comb begin
    for (int k = 0; k < MXKEY; k++) begin
      int                 diff;
      logic               in_win;
      logic [MXHOLDB-1:0] dec;
      diff   = k - int'(best_key);
      in_win = (diff >= -SPREAD) && (diff <= SPREAD);
      dec    = (cnt_q[k] != '0) ? cnt_q[k] - MXHOLDB'(1) : '0;
      if (flush)
        cnt_d[k] = '0;
      else if (acc_d && in_win)
        cnt_d[k] = (busy_hold > dec) ? busy_hold : dec;
      else
        cnt_d[k] = dec;
      bsy_d[k] = cnt_d[k] != '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < MXKEY; k++) cnt_q[k] <= '0;
      bsy_q  <= '0;
      any_q  <= 1'b0;
      acc_q  <= 1'b0;
      lcnt_q <= '0;
    end else begin
      for (int k = 0; k < MXKEY; k++) cnt_q[k] <= cnt_d[k];
      bsy_q  <= bsy_d;
      any_q  <= |bsy_d;
      acc_q  <= acc_d;
      lcnt_q <= lcnt_d;
    end
  end

  assign bsy          = bsy_q;
  assign bsy_any      = any_q;
  assign accept       = acc_q;
  assign launch_count = lcnt_q;

endmodule

// File: tb/tb_clct_busy_mask_cclut.sv
// Randomized + directed bench for clct_busy_mask_cclut against an
// expiry-time reference model.
module tb_clct_busy_mask_cclut;

  localparam int SPREAD = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        launch = 1'b0;
  logic [4:0]  best_key = '0;
  logic [6:0]  best_pat = '0;
  logic        best_bsy = 1'b0;
  logic [2:0]  hit_thresh = '0;
  logic [3:0]  busy_hold = '0;
  logic        flush = 1'b0;
  logic [31:0] bsy;
  logic        bsy_any;
  logic        accept;
  logic [15:0] launch_count;

  int checks = 0;
  int fails  = 0;

  // Model: key k is busy during cycle m iff exp_until[k] >= m.
  longint      exp_until [32];
  longint      now = 0;
  logic        macc = 1'b0;
  logic [15:0] mcount = '0;

  clct_busy_mask_cclut dut (
    .clock(clock), .reset(reset), .launch(launch),
    .best_key(best_key), .best_pat(best_pat), .best_bsy(best_bsy),
    .hit_thresh(hit_thresh), .busy_hold(busy_hold), .flush(flush),
    .bsy(bsy), .bsy_any(bsy_any), .accept(accept),
    .launch_count(launch_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] exp_bsy();
    logic [31:0] m;
    for (int k = 0; k < 32; k++) m[k] = exp_until[k] >= now;
    return m;
  endfunction

  task automatic tick();
    logic   a;
    int     hits;
    longint lim;
    hits = int'(best_pat) / 16;
    a = !reset && !flush && launch && !best_bsy
        && hits >= int'(hit_thresh) && busy_hold != 0;
    @(posedge clock);
    if (reset || flush)
      for (int k = 0; k < 32; k++) exp_until[k] = now;
    if (reset) mcount = 0;
    if (a) begin
      lim = now + longint'(busy_hold);
      for (int k = int'(best_key) - SPREAD;
           k <= int'(best_key) + SPREAD; k++)
        if (k >= 0 && k < 32 && exp_until[k] < lim)
          exp_until[k] = lim;
      if (mcount != 16'hFFFF) mcount = mcount + 1;
    end
    macc = a;
    now++;
    #1;
  endtask

  task automatic set_launch(input int key, input int pat,
                            input int thr, input int hold);
    launch     = 1'b1;
    best_key   = 5'(key);
    best_pat   = 7'(pat);
    hit_thresh = 3'(thr);
    busy_hold  = 4'(hold);
    best_bsy   = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 32; k++) exp_until[k] = -1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({bsy, bsy_any, accept, launch_count} !== '0) begin
      fails++;
      $display("FAIL reset: bsy=%h any=%b acc=%b cnt=%0d want all 0",
               bsy, bsy_any, accept, launch_count);
    end
  endtask

  task automatic test_basic();
    logic [31:0] want;
    set_launch(10, 'h60, 4, 3);
    tick();
    launch = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      want = (i <= 3) ? 32'h0000_1F00 : 32'h0;
      checks++;
      if (bsy !== want || accept !== (i == 1) || launch_count !== 16'd1) begin
        fails++;
        $display("FAIL basic c%0d: bsy=%h acc=%b cnt=%0d want %h %b 1",
                 i, bsy, accept, launch_count, want, i == 1);
      end
      tick();
    end
  endtask

  task automatic test_edges();
    logic [31:0] want;
    for (int e = 0; e < 2; e++) begin
      set_launch(e == 0 ? 0 : 31, 'h70, 1, 2);
      tick();
      launch = 1'b0;
      for (int i = 1; i <= 3; i++) begin
        want = (i > 2) ? 32'h0 : (e == 0 ? 32'h0000_0007 : 32'hE000_0000);
        checks++;
        if (bsy !== want || bsy !== exp_bsy()) begin
          fails++;
          $display("FAIL edge%0d c%0d: bsy=%h want %h", e, i, bsy, want);
        end
        tick();
      end
    end
  endtask

  task automatic test_rejects();
    logic [15:0] c0;
    c0 = launch_count;
    for (int r = 0; r < 3; r++) begin
      set_launch(16, r == 1 ? 'h30 : 'h60, 4, r == 2 ? 0 : 5);
      best_bsy = (r == 0);
      tick();
      launch = 1'b0;
      best_bsy = 1'b0;
      checks++;
      if (bsy !== '0 || accept !== 1'b0 || launch_count !== c0) begin
        fails++;
        $display("FAIL reject%0d: bsy=%h acc=%b cnt=%0d want 0 0 %0d",
                 r, bsy, accept, launch_count, c0);
      end
      tick();
    end
  endtask

  task automatic test_overlap();
    set_launch(10, 'h60, 4, 4);
    tick();
    launch = 1'b0;
    tick();
    set_launch(13, 'h60, 4, 4);
    tick();
    launch = 1'b0;
    // now at N+3; walk N+3..N+7
    for (int i = 3; i <= 7; i++) begin
      checks++;
      if (bsy[10:8] !== {3{i <= 4}} || bsy[12:11] !== {2{i <= 6}}
          || bsy[15:13] !== {3{i <= 6}} || bsy_any !== (i <= 6)) begin
        fails++;
        $display("FAIL overlap N+%0d: bsy=%h any=%b", i, bsy, bsy_any);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [15:0] c0;
    set_launch(5, 'h60, 4, 8);
    tick();
    launch = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (bsy !== '0 || bsy_any !== 1'b0) begin
      fails++;
      $display("FAIL flush: bsy=%h any=%b want 0", bsy, bsy_any);
    end
    c0 = launch_count;
    set_launch(20, 'h60, 4, 8);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    launch = 1'b0;
    checks++;
    if (bsy !== '0 || accept !== 1'b0 || launch_count !== c0) begin
      fails++;
      $display("FAIL flush_launch: bsy=%h acc=%b cnt=%0d want 0 0 %0d",
               bsy, accept, launch_count, c0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      launch     = $urandom_range(0, 1) == 1;
      best_key   = 5'($urandom_range(0, 31));
      best_pat   = 7'($urandom);
      best_bsy   = $urandom_range(0, 4) == 0;
      hit_thresh = 3'($urandom);
      busy_hold  = 4'($urandom);
      flush      = $urandom_range(0, 15) == 0;
      tick();
      checks++;
      if ({bsy, bsy_any, accept, launch_count}
          !== {exp_bsy(), |exp_bsy(), macc, mcount}) begin
        fails++;
        $display("FAIL random i%0d: bsy=%h any=%b acc=%b cnt=%0d want %h %b %b %0d",
                 i, bsy, bsy_any, accept, launch_count,
                 exp_bsy(), |exp_bsy(), macc, mcount);
      end
    end
    launch = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_launch(7, 'h70, 0, 1);
    for (int i = 0; i < 65537; i++) begin
      best_key = 5'(i);
      tick();
    end
    checks++;
    if (launch_count !== 16'hFFFF || launch_count !== mcount || accept !== 1'b1) begin
      fails++;
      $display("FAIL saturate: cnt=%h acc=%b want ffff 1", launch_count, accept);
    end
    launch = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_launch(12, 'h60, 2, 15);
    tick();
    checks++;
    if (bsy !== 32'h0000_7C00 || accept !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: bsy=%h acc=%b want 00007c00 1", bsy, accept);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    launch = 1'b0;
    checks++;
    if ({bsy, bsy_any, accept, launch_count} !== '0) begin
      fails++;
      $display("FAIL reset_mid: bsy=%h any=%b acc=%b cnt=%0d want all 0",
               bsy, bsy_any, accept, launch_count);
    end
    tick();
    checks++;
    if (bsy !== exp_bsy() || bsy !== '0) begin
      fails++;
      $display("FAIL post_reset: bsy=%h want 0", bsy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_rejects();
    test_overlap();
    test_flush();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/clct_busy_mask_cclut.md
Name: clct_busy_mask_ccLUT

Overview:
- Feedback partner of the ccLUT best-1-of-32 key sorter. Consumes the sorter winner (best_key/best_pat/best_bsy) plus a launch strobe, and generates the per-key busy mask driven back into the sorter's bsy input.
- Each accepted winner blanks its own key and +/-SPREAD neighbouring keys for busy_hold clocks, so the next sort finds a distinct pattern.
- Sits between the pattern-finder sort tree and the pretrigger/drift logic, in the same clock domain.

Parameters:
MXKEY, 32, number of 1/2-strip keys (mask width)
MXKEYB, 5, key index width
MXPATB, 7, pattern word width: [6:4] hit count, [3:0] pattern/bend id
SPREAD, 2, neighbour half-width blanked around a launched key (0..7)
MXHOLDB, 4, per-key countdown width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
launch  in  1  pretrigger strobe; qualifies winner this cycle
best_key  in  MXKEYB  sorter winning key
best_pat  in  MXPATB  sorter winning pattern
best_bsy  in  1  winner was already busy
hit_thresh  in  3  min hit count (best_pat[6:4]) to accept
busy_hold  in  MXHOLDB  clocks a blanked key stays busy; 0 disables blanking
flush  in  1  clear all busy state (readout/resync)
bsy  out  MXKEY  registered per-key busy mask to sorter
bsy_any  out  1  OR of bsy, registered with bsy
accept  out  1  registered: a launch was accepted last cycle
launch_count  out  16  saturating count of accepted launches

Behaviour:
- Reset (synchronous): all countdowns=0, bsy=0, bsy_any=0, accept=0, launch_count=0. Reset mid-countdown clears immediately at the next edge. Reset dominates flush and launch.
- Accept condition, evaluated in cycle N:
  - launch=1 & best_bsy=0 & best_pat[6:4] >= hit_thresh & best_key < MXKEY & busy_hold != 0.
  - hit_thresh=0 accepts any non-busy winner.
- Per-key countdown cnt[k], MXHOLDB bits. Each clock:
  - if flush: cnt[k]=0.
  - else if accept & |k - best_key| <= SPREAD: cnt[k] = max(cnt[k]-1 saturating at 0, busy_hold). Retrigger extends the count, never shortens it.
  - else: cnt[k] = cnt[k]-1 if nonzero.
- Window clipping at the edges:
  - Keys below 0 or above MXKEY-1 are ignored.
  - best_key=0 with SPREAD=2 blanks keys 0..2. best_key=31 blanks keys 29..31.
  - No wrap-around.
- Output registers:
  - bsy[k] = (next cnt[k] != 0), registered with cnt. bsy_any = |next bsy.
  - Accept in cycle N gives bsy high on cycles N+1 .. N+busy_hold inclusive, exactly busy_hold clocks, then low at N+busy_hold+1.
- Latency: 1 clock from launch to bsy. The sorter registers the 2-of-4 stage, so its winner at N+1 already reflects pre-mask data. This one-cycle exposure is inherent and accepted.
- Simultaneous flush & launch: flush wins. No key is blanked, accept=0, count does not increment.
- accept output: registered copy of the accept condition, high for 1 clock at N+1.
- launch_count: +1 per accept, saturates at 16'hFFFF, cleared only by reset (not by flush).
- Overlapping windows from successive launches OR naturally, because each key has its own counter.
- busy_hold is sampled only at accept time. Changing it later does not alter running countdowns.
- No combinational path from any input to any output.

Test Plan:
- Reset, then launch with best_key=10, best_pat=7'h60 (hits=6), hit_thresh=4, busy_hold=3, best_bsy=0 at cycle N -> bsy=32'h0000_1F00 (keys 8..12) on N+1..N+3; 0 at N+4; accept=1 only at N+1; launch_count=1.
- Edge clipping: best_key=0 with busy_hold=2 -> bsy=32'h0000_0007 for 2 clocks. Then best_key=31 -> bsy=32'hE000_0000 for 2 clocks.
- Rejects:
  - best_bsy=1 -> bsy stays 0, accept=0, count unchanged.
  - best_pat hits=3 with hit_thresh=4 -> bsy stays 0, accept=0, count unchanged.
  - busy_hold=0 -> bsy stays 0, accept=0, count unchanged.
- Retrigger and overlap: key 10 with hold=4 at N, then key 13 with hold=4 at N+2.
  - Keys 8..10 low after N+4.
  - Keys 11..12 busy N+1..N+6.
  - Keys 13..15 busy N+3..N+6.
  - bsy_any continuous N+1..N+6.
- Flush: flush=1 at N+2 during an active window -> bsy=0 from N+3. flush and launch together -> no blanking, count unchanged.
- Saturation and reset: force 65537 accepts -> launch_count=16'hFFFF. Assert reset during an active window -> all outputs 0 at the next edge.
